// File: rtl/pixel_scan_pkg.sv
// Shared types and widths for the pixel scan sequencer.
// The optional back-to-back frame mode is built in with PIXEL_SCAN_CONTINUOUS_EN.
package pixel_scan_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    // Credit counter must hold 0..MAX_INFLIGHT inclusive.
    function automatic int credit_w(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    typedef logic [credit_w(32)-1:0] credit_t;

endpackage

// File: rtl/pixel_scan_sequencer_credit_counter.sv
// Credit pool for rays in flight: one credit taken per issued pair, one returned per retire.
// Over-return while full is flagged in a sticky err_credit.
module credit_counter
    import pixel_scan_pkg::*;
#(
    parameter  int MAX_INFLIGHT = 32,
    localparam int CW           = credit_w(MAX_INFLIGHT)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          consume,
    input  logic          retire,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          err_credit
);

    localparam logic [CW-1:0] FULL = CW'(MAX_INFLIGHT);

    logic over_return;

    // consume is only raised while credits are available, so no underflow guard.
    always_comb begin
        count_next  = count;
        over_return = retire && !consume && (count == FULL);
        if (consume && !retire) begin
            count_next = count - CW'(1);
        end else if (retire && !consume && (count != FULL)) begin
            count_next = count + CW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count      <= FULL;
            err_credit <= 1'b0;
        end else begin
            count <= count_next;
            if (over_return) begin
                err_credit <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Raster-order (hcount, vcount) issue to the ray pipeline, bounded by a credit pool.
// Define PIXEL_SCAN_CONTINUOUS_EN to add the 'continuous' input for back-to-back frames.
module pixel_scan_sequencer
    import pixel_scan_pkg::*;
#(
    parameter int H_PIXELS     = 1280,
    parameter int V_PIXELS     = 720,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              start,
`ifdef PIXEL_SCAN_CONTINUOUS_EN
    input  logic                              continuous,
`endif
    output logic                              busy,
    output logic                              frame_done,
    output logic [HCOUNT_W-1:0]               hcount_axis_tdata,
    output logic                              hcount_axis_tvalid,
    input  logic                              hcount_axis_tready,
    output logic [VCOUNT_W-1:0]               vcount_axis_tdata,
    output logic                              vcount_axis_tvalid,
    input  logic                              vcount_axis_tready,
    input  logic                              ray_retire,
    output logic                              err_credit,
    output state_t                            fsm_state,
    output logic [credit_w(MAX_INFLIGHT)-1:0] credits
);

    localparam int            CW   = credit_w(MAX_INFLIGHT);
    localparam logic [CW-1:0] FULL = CW'(MAX_INFLIGHT);

    // Channel handshake: a transfer happens on a rising aclk edge where tvalid & tready;
    // tvalid is registered-state only, never a function of tready, and once raised
    // holds with stable tdata until its own channel handshakes.
    state_t              state, state_next;
    logic [HCOUNT_W-1:0] h;
    logic [VCOUNT_W-1:0] v;
    logic                pending, h_acc, v_acc;
    logic                h_hs, v_hs, complete, last_pair;
    logic [CW-1:0]       credits_next;
    logic                cont_q;

    assign hcount_axis_tvalid = pending && !h_acc;
    assign vcount_axis_tvalid = pending && !v_acc;
    assign hcount_axis_tdata  = h;
    assign vcount_axis_tdata  = v;
    assign h_hs       = hcount_axis_tvalid && hcount_axis_tready;
    assign v_hs       = vcount_axis_tvalid && vcount_axis_tready;
    assign complete   = pending && (h_acc || h_hs) && (v_acc || v_hs);
    assign last_pair  = (h == HCOUNT_W'(H_PIXELS - 1)) && (v == VCOUNT_W'(V_PIXELS - 1));
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    credit_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_credit (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .consume    (complete),
        .retire     (ray_retire),
        .count      (credits),
        .count_next (credits_next),
        .err_credit (err_credit)
    );

`ifdef PIXEL_SCAN_CONTINUOUS_EN
    // Decision to chain into the next frame is taken when the last pair completes.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cont_q <= 1'b0;
        end else if (complete && last_pair) begin
            cont_q <= continuous;
        end
    end
`else
    assign cont_q = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ISSUE;
            ISSUE: if (complete && last_pair) state_next = DRAIN;
            DRAIN: begin
                if (credits == FULL) begin
                    if (cont_q) begin
                        frame_done = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The next pair is raised straight off a completion when a credit survives it,
    // which gives one pair per cycle with both readys held high.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            h       <= '0;
            v       <= '0;
            pending <= 1'b0;
            h_acc   <= 1'b0;
            v_acc   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                h <= '0;
                v <= '0;
            end
            if (complete) begin
                h_acc   <= 1'b0;
                v_acc   <= 1'b0;
                pending <= !last_pair && (credits_next != '0);
                if (h == HCOUNT_W'(H_PIXELS - 1)) begin
                    h <= '0;
                    v <= last_pair ? '0 : v + VCOUNT_W'(1);
                end else begin
                    h <= h + HCOUNT_W'(1);
                end
            end else if (pending) begin
                h_acc <= h_acc || h_hs;
                v_acc <= v_acc || v_hs;
            end else if (state == ISSUE) begin
                pending <= (credits_next != '0);
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer at H=4, V=3, MAX_INFLIGHT=2.
// The continuous-frame scenario is compiled in only with PIXEL_SCAN_CONTINUOUS_EN.
module tb_pixel_scan_sequencer;
    import pixel_scan_pkg::*;

    logic        aclk;
    logic        aresetn, start, hr, vr, retire_manual, retire_echo, ray_retire;
    logic        busy, frame_done, hv, vv, err_credit;
    logic [10:0] hdata;
    logic [9:0]  vdata;
    logic [1:0]  credits;
    state_t      fsm_state;
    logic        echo_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ret_cyc = 0;

    logic [20:0] got_q[$];
    logic [20:0] exp_q[$];
    int          due_q[$];
    logic        seen_h = 0, seen_v = 0;
    logic [10:0] cap_h;
    logic [9:0]  cap_v;

    typedef struct {
        logic        hr, vr, ret;
        logic        ehv, evv;
        logic [10:0] eh;
        logic [9:0]  ev;
        logic [1:0]  ecr;
        logic        eerr;
    } vec_t;
    vec_t vecs[12];

    assign ray_retire = retire_manual | retire_echo;

    pixel_scan_sequencer #(.H_PIXELS(4), .V_PIXELS(3), .MAX_INFLIGHT(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
`ifdef PIXEL_SCAN_CONTINUOUS_EN
        .continuous(1'b0),
`endif
        .busy(busy), .frame_done(frame_done),
        .hcount_axis_tdata(hdata), .hcount_axis_tvalid(hv), .hcount_axis_tready(hr),
        .vcount_axis_tdata(vdata), .vcount_axis_tvalid(vv), .vcount_axis_tready(vr),
        .ray_retire(ray_retire), .err_credit(err_credit),
        .fsm_state(fsm_state), .credits(credits)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Negedge observer: collects completed pairs and echoes each completion as a retire.
    always @(negedge aclk) begin
        logic comp;
        comp = 1'b0;
        if (!aresetn) begin
            seen_h = 1'b0;
            seen_v = 1'b0;
        end else begin
            if (hv && hr) begin seen_h = 1'b1; cap_h = hdata; end
            if (vv && vr) begin seen_v = 1'b1; cap_v = vdata; end
            if (seen_h && seen_v) begin
                got_q.push_back({cap_v, cap_h});
                seen_h = 1'b0;
                seen_v = 1'b0;
                comp = 1'b1;
            end
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        retire_echo = 1'b0;
        if (!echo_en) begin
            due_q.delete();
        end else begin
            if (due_q.size() != 0 && due_q[0] == cyc + 1) begin
                retire_echo  = 1'b1;
                last_ret_cyc = cyc;
                void'(due_q.pop_front());
            end
            if (comp) due_q.push_back(cyc + 4);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge aclk); #1 aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
    endtask

    // Returns at a negedge where hcount tvalid is high, or ok=0 after the budget.
    task automatic wait_hvalid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (hv) begin ok = 1'b1; return; end
        end
    endtask

`ifdef PIXEL_SCAN_CONTINUOUS_EN
    logic        c_start = 0, c_cont = 0, c_ret = 0, c_comp_prev = 0;
    logic        c_busy, c_done, c_hv, c_vv, c_err;
    logic [10:0] c_h;
    logic [9:0]  c_v;
    logic [2:0]  c_credits;
    state_t      c_state;
    int          c_done_cnt = 0;
    bit          c_started = 0, c_drop = 0;
    logic [20:0] c_got_q[$];

    pixel_scan_sequencer #(.H_PIXELS(2), .V_PIXELS(2), .MAX_INFLIGHT(4)) u_cont (
        .aclk(aclk), .aresetn(aresetn), .start(c_start), .continuous(c_cont),
        .busy(c_busy), .frame_done(c_done),
        .hcount_axis_tdata(c_h), .hcount_axis_tvalid(c_hv), .hcount_axis_tready(1'b1),
        .vcount_axis_tdata(c_v), .vcount_axis_tvalid(c_vv), .vcount_axis_tready(1'b1),
        .ray_retire(c_ret), .err_credit(c_err),
        .fsm_state(c_state), .credits(c_credits)
    );

    // Both readys tied high, so every valid cycle completes a pair; retire one cycle later.
    always @(negedge aclk) begin
        c_ret = c_comp_prev;
        c_comp_prev = c_hv && c_vv && aresetn;
        if (c_hv && c_vv) c_got_q.push_back({c_v, c_h});
        if (c_done) c_done_cnt = c_done_cnt + 1;
        if (c_busy) c_started = 1'b1;
        if (c_started && !c_busy && c_done_cnt < 2) c_drop = 1'b1;
    end
`endif

    initial begin
        bit ok;
        bit found;
        int base;

        aresetn = 1'b0; start = 1'b0; hr = 1'b0; vr = 1'b0;
        retire_manual = 1'b0; echo_en = 1'b0;

        //             hr  vr  ret  hv  vv  h  v  cr err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd1, 10'd0, 2'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'd1, 10'd0, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'd2, 10'd0, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'd2, 10'd0, 2'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd2, 10'd0, 2'd2, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd2, 10'd0, 2'd2, 1'b1};

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_hvalid", 32'(hv), 0);
        check("rst_vvalid", 32'(vv), 0);
        check("rst_hdata", 32'(hdata), 0);
        check("rst_vdata", 32'(vdata), 0);
        check("rst_credits", 32'(credits), 2);
        check("rst_err", 32'(err_credit), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        @(posedge aclk); #1 aresetn = 1'b1;

        // Full frame with retires echoed 3 cycles after each completion.
        hr = 1'b1; vr = 1'b1; echo_en = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 12; i++) exp_q.push_back({10'(i / 4), 11'(i % 4)});
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge aclk);
            if (done_cnt >= 1) found = 1'b1;
        end
        check("t1_done_seen", 32'(found), 1);
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        check("t1_pair_count", 32'(got_q.size() - base), 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < got_q.size()) check("t1_pair", 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        check("t1_done_count", 32'(done_cnt), 1);
        check("t1_done_after_retire", 32'(done_cyc > last_ret_cyc), 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_state_after", 32'(fsm_state), 32'(IDLE));
        check("t1_credits_after", 32'(credits), 2);

        // No retires: the pool allows two pairs, then a single retire releases one more.
        @(posedge aclk); #1 echo_en = 1'b0;
        base = got_q.size();
        pulse_start();
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        check("t2_pairs_stalled", 32'(got_q.size() - base), 2);
        check("t2_hvalid_stalled", 32'(hv), 0);
        check("t2_vvalid_stalled", 32'(vv), 0);
        check("t2_credits_zero", 32'(credits), 0);
        @(posedge aclk); #1 retire_manual = 1'b1;
        @(posedge aclk); #1 retire_manual = 1'b0;
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        check("t2_pairs_released", 32'(got_q.size() - base), 3);
        check("t2_hvalid_after", 32'(hv), 0);
        check("t2_third_pair", 32'(got_q[got_q.size() - 1]), 32'({10'd0, 11'd2}));

        // vcount back-pressure, then completion+retire and over-return, cycle by cycle.
        do_reset();
        hr = 1'b1; vr = 1'b0;
        pulse_start();
        wait_hvalid(20, ok);
        check("t3_first_valid", 32'(ok), 1);
        if (ok) begin
            for (int k = 0; k < 12; k++) begin
                if (k > 0) @(negedge aclk);
                hr = vecs[k].hr; vr = vecs[k].vr; retire_manual = vecs[k].ret;
                check($sformatf("t3_hvalid[%0d]", k), 32'(hv), 32'(vecs[k].ehv));
                check($sformatf("t3_vvalid[%0d]", k), 32'(vv), 32'(vecs[k].evv));
                if (vecs[k].ehv) check($sformatf("t3_hdata[%0d]", k), 32'(hdata), 32'(vecs[k].eh));
                if (vecs[k].evv) check($sformatf("t3_vdata[%0d]", k), 32'(vdata), 32'(vecs[k].ev));
                check($sformatf("t3_credits[%0d]", k), 32'(credits), 32'(vecs[k].ecr));
                check($sformatf("t3_err[%0d]", k), 32'(err_credit), 32'(vecs[k].eerr));
                @(posedge aclk);
            end
        end
        #1 retire_manual = 1'b0;

        // Reset mid-frame while pair (2,1) is presented.
        do_reset();
        check("t5_err_cleared", 32'(err_credit), 0);
        hr = 1'b1; vr = 1'b1; echo_en = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (hv && hdata == 11'd2 && vdata == 10'd1) found = 1'b1;
        end
        check("t5_reached_2_1", 32'(found), 1);
        aresetn = 1'b0; echo_en = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        check("t5_hvalid", 32'(hv), 0);
        check("t5_vvalid", 32'(vv), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_credits", 32'(credits), 2);
        pulse_start();
        wait_hvalid(20, ok);
        check("t5_restart_valid", 32'(ok), 1);
        check("t5_restart_h", 32'(hdata), 0);
        check("t5_restart_v", 32'(vdata), 0);

`ifdef PIXEL_SCAN_CONTINUOUS_EN
        // Two chained 2x2 frames with continuous held until the first frame_done.
        do_reset();
        c_cont = 1'b1;
        @(posedge aclk); #1 c_start = 1'b1;
        @(posedge aclk); #1 c_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (c_done_cnt >= 1) found = 1'b1;
        end
        check("t6_first_done", 32'(found), 1);
        c_cont = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (c_done_cnt >= 2) found = 1'b1;
        end
        check("t6_second_done", 32'(found), 1);
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("t6_done_count", 32'(c_done_cnt), 2);
        check("t6_busy_held", 32'(c_drop), 0);
        check("t6_busy_end", 32'(c_busy), 0);
        check("t6_pair_count", 32'(c_got_q.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < c_got_q.size())
                check("t6_pair", 32'(c_got_q[i]), 32'({10'((i % 4) / 2), 11'(i % 2)}));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_scan_sequencer.md
Name: pixel_scan_sequencer

Overview:
- Sequences the ray-generation datapath for one frame by producing raster-order (hcount, vcount) pairs on two AXI-stream channels that feed the pixel-to-ray converter.
- Bounds rays in flight with a credit counter. Downstream retires a credit per completed ray.
- Sits between the frame-level render controller (start/done) and the ray pipeline (24-cycle latency).

Parameters:
- H_PIXELS, 1280: pixels per line; hcount range 0..H_PIXELS-1.
- V_PIXELS, 720: lines per frame; vcount range 0..V_PIXELS-1.
- MAX_INFLIGHT, 32: credit pool size. Must be >= 1; values >= 24 are needed for full throughput.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- start  in  1  pulse; begins a frame when idle.
- busy  out  1  high from the accepted start until the frame_done cycle inclusive.
- frame_done  out  1  one-cycle pulse after the last ray retires.
- hcount_axis_tdata  out  11  pixel column.
- hcount_axis_tvalid  out  1  column valid.
- hcount_axis_tready  in  1  column accepted.
- vcount_axis_tdata  out  10  pixel row.
- vcount_axis_tvalid  out  1  row valid.
- vcount_axis_tready  in  1  row accepted.
- ray_retire  in  1  pulse; one ray left the pipeline and returns one credit.
- err_credit  out  1  sticky; a retire arrived while the credit pool was full.

Behaviour:
- Reset (aresetn low at an aclk edge): state IDLE; busy=0; frame_done=0; both tvalid=0; both tdata=0; credits=MAX_INFLIGHT; err_credit=0. Reset mid-frame abandons the frame immediately, with no drain.
- States and transitions:
  - IDLE: on start go to ISSUE with h=0, v=0. start in any other state is ignored.
  - ISSUE: present pairs (rules below). When the pair h=H_PIXELS-1, v=V_PIXELS-1 completes, go to DRAIN.
  - DRAIN: when credits==MAX_INFLIGHT, go to DONE.
  - DONE: frame_done=1 and busy=1 for one cycle, then IDLE.
- Presentation:
  - In ISSUE, when no pair is outstanding and credits>0, assert both tvalid in the same cycle, with tdata = current h and v.
  - tvalid never depends on tready in the same cycle.
  - Once asserted, each tvalid and its tdata hold until that channel handshakes (tvalid & tready). Each channel then drops its tvalid independently.
  - A per-channel "accepted" flag records a handshake.
  - The pair completes in the cycle the second handshake occurs, or when both handshake in the same cycle.
- Credits and raster advance:
  - On pair completion, credits decrement by 1.
  - Raster advances: h+1, or h=0 and v+1 at h=H_PIXELS-1.
  - The next pair may be presented the following cycle, giving 1 pair/cycle sustained when both readys are held high.
- Credit arithmetic:
  - Counter width is $clog2(MAX_INFLIGHT+1).
  - Completion and retire in the same cycle leave credits unchanged.
  - Retire alone increments credits.
  - Retire with credits==MAX_INFLIGHT (and no completion) leaves credits unchanged and sets err_credit. err_credit clears only on reset.
  - Retires are honoured in every state, including IDLE.
- Stall: with credits==0 and no pair outstanding, both tvalid stay low until a retire arrives.

Optional Feature:
- Macro: PIXEL_SCAN_CONTINUOUS_EN.
- With the macro defined:
  - Extra input `continuous` (1 bit).
  - If continuous=1 when the last pair completes, the block pulses frame_done in the cycle the drain condition is met, then returns directly to ISSUE at h=0, v=0. busy stays high.
  - Deasserting `continuous` lets the current frame finish normally.
- Without the macro: the port is absent and every frame requires a start.

Decomposition:
- Shared package pixel_scan_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - HCOUNT_W=11 and VCOUNT_W=10;
  - a typedef for the credit counter width function.
- One natural sub-module, credit_counter: it encapsulates the increment/decrement, saturation and err_credit logic, with parameter MAX_INFLIGHT.
- FSM and raster counters stay in the top module.

Test Plan (H_PIXELS=4, V_PIXELS=3, MAX_INFLIGHT=2 unless noted):
1. Reset then start, both treadys=1, ray_retire echoed 3 cycles after each completion:
   - Expect 12 pairs in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
   - Expect frame_done exactly once, after the 12th retire.
   - Expect busy low afterward.
2. No retires after start:
   - Expect exactly 2 pairs, then tvalid=0 indefinitely.
   - A single retire releases exactly 1 more pair.
3. hcount_tready=1, vcount_tready low for 5 cycles:
   - hcount_tvalid drops after 1 cycle.
   - vcount_tvalid and data hold for 5 cycles.
   - The pair completes on the vcount handshake, and credits go 2->1 only then.
4. Completion and ray_retire in the same cycle at credits=1: credits remain 1. Extra retire at credits=2: err_credit=1 and stays set.
5. aresetn low for 1 cycle mid-frame at pair (2,1):
   - Next cycle both tvalid=0, busy=0, credits=2.
   - A new start begins at (0,0).
6. PIXEL_SCAN_CONTINUOUS_EN defined, continuous=1, H=2, V=2, MAX_INFLIGHT=4: two back-to-back frames of 4 pairs each, 2 frame_done pulses, busy never drops between frames.
